mul_div_unit: RTL

- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits beside the combinational ALU in the EX stage; the ALU keeps single-cycle ops, this block takes MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Exposes busy so hazard logic stalls MFHI/MFLO and further MDU ops.
- Generalises the datapath width and the multiply latency; adds flush and divide-by-zero handling.

---
 rtl/mul_div_unit_pkg.sv | 43 ++++
 rtl/mul_div_unit_div_iter.sv | 71 +++++++
 rtl/mul_div_unit.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_pkg.sv
// Shared definitions for the multiply/divide unit (MDU).
// Contents:
//   MDU_OP_W      width of the op field
//   mdu_op_t      MDU operation codes
//   mdu_state_t   control FSM states
//   op_is_mul     true for ops that take the multiply path
//   op_is_div     true for ops that take the divide path
// Optional feature macro: MDU_MADD_EN (ops 6/7 become MADD/MSUB).
package mul_div_unit_pkg;

  localparam int MDU_OP_W = 3;

  typedef enum logic [MDU_OP_W-1:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MADD  = 3'd6,
    OP_MSUB  = 3'd7
  } mdu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } mdu_state_t;

  // Ops 6/7 only reach the multiplier when the accumulate group is built in.
  function automatic logic op_is_mul(input logic [MDU_OP_W-1:0] op);
`ifdef MDU_MADD_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) || (op == OP_MSUB);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

  function automatic logic op_is_div(input logic [MDU_OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mul_div_unit_div_iter.sv
// Iterative restoring divider, one quotient bit per clock, WIDTH iterations.
// Works on unsigned magnitudes only; sign fix-up and special cases belong to
// the parent.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start             load dividend/divisor and begin (parent only pulses when idle)
//   abort             cancel any division in flight
//   dividend, divisor unsigned operands sampled on start
//   done              high during the final iteration cycle
//   quotient          quotient value the final iteration produces (valid with done)
//   remainder         remainder value the final iteration produces (valid with done)
module mul_div_unit_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [CNT_W-1:0] count;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dsr_q;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   diff;
  logic             fits;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. quo_q starts as the
  // dividend and is shifted left, so quotient bits fill in from the bottom.
  // The step result is exported directly so the parent can commit it on the
  // same edge as the last iteration.
  always_comb begin
    shifted   = {rem_q, quo_q[WIDTH-1]};
    diff      = shifted - {1'b0, dsr_q};
    fits      = ~diff[WIDTH];
    remainder = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quotient  = {quo_q[WIDTH-2:0], fits};
    done      = (count == CNT_W'(1));
  end

  // Iteration registers; count==0 means idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      rem_q <= '0;
      quo_q <= '0;
      dsr_q <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (start) begin
      count <= CNT_W'(WIDTH);
      rem_q <= '0;
      quo_q <= dividend;
      dsr_q <= divisor;
    end else if (count != '0) begin
      count <= count - 1'b1;
      rem_q <= remainder;
      quo_q <= quotient;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Handles MULT/MULTU (MUL_CYCLES latency), DIV/DIVU (WIDTH cycles), MTHI/MTLO
// (single cycle). Results go to HI/LO atomically in one edge.
// Optional feature macro: MDU_MADD_EN adds op 6 MADD and op 7 MSUB, which
// accumulate a signed product into {hi,lo}; without it ops 6/7 are ignored.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start, op    request and operation code (sampled while busy==0)
//   srcA, srcB   rs / rt operands
//   flush        cancel the operation in flight (beats start)
//   busy         a MUL or DIV is in progress
//   done         one-cycle pulse alongside a MUL/DIV result landing in HI/LO
//   hi, lo       HI and LO registers
module mul_div_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] srcA,
  input  logic [WIDTH-1:0] srcB,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  import mul_div_unit_pkg::*;

  localparam int CNT_W = (MUL_CYCLES < 2) ? 1 : $clog2(MUL_CYCLES + 1);

  mdu_state_t       state;
  mdu_state_t       state_next;
  logic [CNT_W-1:0] mul_count;
  mdu_op_t          op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;

  logic             accept;
  logic             is_mul_op;
  logic             is_div_op;
  logic             mul_write;
  logic             div_write;
  logic             div_start;
  logic             div_done;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dsr_mag;

  logic               mul_signed;
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] product;
  logic [2*WIDTH-1:0] mul_result;

  logic             div_signed;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] div_hi;
  logic [WIDTH-1:0] div_lo;

  // Request decode. flush wins over start, so a flushed start is never seen.
  always_comb begin
    is_mul_op = op_is_mul(op);
    is_div_op = op_is_div(op);
    accept    = (state == ST_IDLE) && start && !flush;
    div_start = accept && is_div_op;
    dvd_mag   = (op == OP_DIV && srcA[WIDTH-1]) ? -srcA : srcA;
    dsr_mag   = (op == OP_DIV && srcB[WIDTH-1]) ? -srcB : srcB;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and control outputs. A write is suppressed when flush lands
  // in the final cycle, leaving HI/LO at their pre-operation values.
  always_comb begin
    state_next = state;
    busy       = (state != ST_IDLE);
    mul_write  = 1'b0;
    div_write  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept && is_mul_op) begin
          state_next = ST_MUL;
        end else if (accept && is_div_op) begin
          state_next = ST_DIV;
        end
      end
      ST_MUL: begin
        mul_write = (mul_count == CNT_W'(1)) && !flush;
        if (flush || mul_count == CNT_W'(1)) begin
          state_next = ST_IDLE;
        end
      end
      ST_DIV: begin
        div_write = div_done && !flush;
        if (flush || div_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Product of the latched operands; both are extended to 2*WIDTH so a single
  // multiplier serves signed and unsigned forms.
  always_comb begin
    mul_signed = (op_q != OP_MULTU);
    ext_a      = {{WIDTH{mul_signed & opa_q[WIDTH-1]}}, opa_q};
    ext_b      = {{WIDTH{mul_signed & opb_q[WIDTH-1]}}, opb_q};
    product    = ext_a * ext_b;
`ifdef MDU_MADD_EN
    if (op_q == OP_MADD) begin
      mul_result = {hi, lo} + product;
    end else if (op_q == OP_MSUB) begin
      mul_result = {hi, lo} - product;
    end else begin
      mul_result = product;
    end
`else
    mul_result = product;
`endif
  end

  // Sign fix-up around the unsigned divider. The most-negative / -1 case
  // needs no special handling: its magnitude quotient negates back to the
  // most-negative value with a zero remainder.
  always_comb begin
    div_signed = (op_q == OP_DIV);
    a_neg      = div_signed & opa_q[WIDTH-1];
    b_neg      = div_signed & opb_q[WIDTH-1];
    div_lo     = (a_neg ^ b_neg) ? -div_quo : div_quo;
    div_hi     = a_neg ? -div_rem : div_rem;
    if (opb_q == '0) begin
      div_lo = '1;
      div_hi = opa_q;
    end
  end

  mul_div_unit_div_iter #(
    .WIDTH(WIDTH)
  ) u_div_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .abort    (flush),
    .dividend (dvd_mag),
    .divisor  (dsr_mag),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  // Operand latch, multiply latency counter, HI/LO and the done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi        <= '0;
      lo        <= '0;
      done      <= 1'b0;
      mul_count <= '0;
      op_q      <= OP_MULT;
      opa_q     <= '0;
      opb_q     <= '0;
    end else begin
      done <= mul_write | div_write;

      if (accept && (is_mul_op || is_div_op)) begin
        op_q  <= mdu_op_t'(op);
        opa_q <= srcA;
        opb_q <= srcB;
      end

      if (flush) begin
        mul_count <= '0;
      end else if (accept && is_mul_op) begin
        mul_count <= CNT_W'(MUL_CYCLES);
      end else if (state == ST_MUL && mul_count != '0) begin
        mul_count <= mul_count - 1'b1;
      end

      if (mul_write) begin
        {hi, lo} <= mul_result;
      end else if (div_write) begin
        hi <= div_hi;
        lo <= div_lo;
      end else if (accept && op == OP_MTHI) begin
        hi <= srcA;
      end else if (accept && op == OP_MTLO) begin
        lo <= srcA;
      end
    end
  end

endmodule
